// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore sequencer driving PC/IR/regfile/ALU strobes of a RISC-V multi-cycle core.
// Latency: 3..5 cycles per instruction with zero-wait memory; outputs decode from the current state.
// Backpressure: holds mem_req until mem_ready; MEM_TIMEOUT unanswered wait cycles trap the core.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic [1:0]       alu_op,
    output logic             alu_src,
    output logic             reg_write,
    output logic [1:0]       mem_to_reg,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instret,
    output logic             busy
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // The counter value seen during the last permitted wait cycle; one more miss trips the timeout.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_ACC,
        S_WB_MEM,
        S_EXEC,
        S_WB_ALU,
        S_BRANCH,
        S_JUMP,
        S_TRAP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [7:0]       wait_cnt;
    logic [1:0]       cause;
    logic [1:0]       cause_nxt;
    logic [CNT_W-1:0] ret_cnt;
    logic             retire;
    logic             wait_hit;

    assign wait_hit = (wait_cnt == WAIT_LAST);

    // State, trap cause and retired-instruction counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_FETCH;
            cause   <= 2'b00;
            ret_cnt <= '0;
        end else begin
            state <= state_nxt;
            cause <= cause_nxt;
            if (retire) begin
                ret_cnt <= ret_cnt + CNT_W'(1);
            end
        end
    end

    // Memory wait counter: restarts per access, counts cycles a request goes unanswered.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (mem_req && mem_ready) begin
            wait_cnt <= '0;
        end else if (mem_req) begin
            wait_cnt <= wait_cnt + 8'd1;
        end else if ((state_nxt != state) &&
                     ((state_nxt == S_FETCH) || (state_nxt == S_MEM_ACC))) begin
            wait_cnt <= '0;
        end
    end

    // Next-state and Moore output decode; reset forces every output low in its own cycle.
    always_comb begin
        state_nxt  = state;
        cause_nxt  = cause;
        retire     = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        alu_op     = 2'b00;
        alu_src    = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 2'b00;
        trap       = 1'b0;
        busy       = 1'b0;
        trap_cause = cause;
        instret    = ret_cnt;

        case (state)
            S_FETCH: begin
                mem_req = run;
                busy    = run;
                if (run) begin
                    if (mem_ready) begin
                        ir_write  = 1'b1;
                        pc_write  = 1'b1;
                        state_nxt = S_DECODE;
                    end else if (wait_hit) begin
                        state_nxt = S_TRAP;
                        cause_nxt = 2'b10;
                    end
                end
            end
            S_DECODE: begin
                busy = 1'b1;
                case (opcode)
                    OP_LOAD, OP_STORE:     state_nxt = S_MEM_ADDR;
                    OP_R, OP_IMM, OP_LUI:  state_nxt = S_EXEC;
                    OP_BRANCH:             state_nxt = S_BRANCH;
                    OP_JAL, OP_JALR:       state_nxt = S_JUMP;
                    default: begin
                        state_nxt = S_TRAP;
                        cause_nxt = 2'b01;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                busy      = 1'b1;
                alu_op    = 2'b01;
                alu_src   = 1'b1;
                state_nxt = S_MEM_ACC;
            end
            S_MEM_ACC: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = (opcode == OP_STORE);
                if (mem_ready) begin
                    if (opcode == OP_STORE) begin
                        retire    = 1'b1;
                        state_nxt = S_FETCH;
                    end else begin
                        state_nxt = S_WB_MEM;
                    end
                end else if (wait_hit) begin
                    state_nxt = S_TRAP;
                    cause_nxt = 2'b10;
                end
            end
            S_WB_MEM: begin
                busy       = 1'b1;
                reg_write  = 1'b1;
                mem_to_reg = 2'b01;
                retire     = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_EXEC, S_WB_ALU: begin
                // ALU controls stay stable through write-back so the result is not disturbed.
                busy = 1'b1;
                case (opcode)
                    OP_IMM: begin
                        alu_src = 1'b1;
                        alu_op  = 2'b00;
                    end
                    OP_LUI: begin
                        alu_src = 1'b1;
                        alu_op  = 2'b11;
                    end
                    default: begin
                        alu_src = 1'b0;
                        alu_op  = 2'b10;
                    end
                endcase
                if (state == S_WB_ALU) begin
                    reg_write = 1'b1;
                    retire    = 1'b1;
                    state_nxt = S_FETCH;
                end else begin
                    state_nxt = S_WB_ALU;
                end
            end
            S_BRANCH: begin
                busy      = 1'b1;
                alu_op    = 2'b11;
                pc_src    = 2'b01;
                pc_write  = branch_taken;
                retire    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_JUMP: begin
                busy       = 1'b1;
                reg_write  = 1'b1;
                mem_to_reg = 2'b10;
                pc_write   = 1'b1;
                if (opcode == OP_JALR) begin
                    pc_src  = 2'b11;
                    alu_src = 1'b1;
                    alu_op  = 2'b01;
                end else begin
                    pc_src = 2'b10;
                end
                retire    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_TRAP: begin
                trap = 1'b1;
            end
            default: begin
                state_nxt = S_FETCH;
            end
        endcase

        if (reset) begin
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            iord       = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            pc_src     = 2'b00;
            alu_op     = 2'b00;
            alu_src    = 1'b0;
            reg_write  = 1'b0;
            mem_to_reg = 2'b00;
            trap       = 1'b0;
            busy       = 1'b0;
            trap_cause = 2'b00;
            instret    = '0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed plus randomized instruction streams against an instruction-level model.
// Latency: every cycle of every instruction is compared, including cycles-per-instruction totals.
// Backpressure: memory wait states are randomized, with timeouts and reset during an access.
module tb_multicycle_ctrl;

    localparam int TO    = 15;
    localparam int CNT_W = 32;

    localparam int C_LOAD = 0, C_STORE = 1, C_R = 2, C_IMM = 3, C_LUI = 4;
    localparam int C_BRANCH = 5, C_JAL = 6, C_JALR = 7, C_ILL = 8;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic [1:0] alu_op;
        logic       alu_src;
        logic       reg_write;
        logic [1:0] mem_to_reg;
        logic       trap;
        logic [1:0] trap_cause;
        logic       busy;
    } ctl_t;

    logic             clk;
    logic             reset;
    logic             run;
    logic [6:0]       opcode;
    logic             branch_taken;
    logic             mem_ready;
    logic             mem_req;
    logic             mem_we;
    logic             iord;
    logic             ir_write;
    logic             pc_write;
    logic [1:0]       pc_src;
    logic [1:0]       alu_op;
    logic             alu_src;
    logic             reg_write;
    logic [1:0]       mem_to_reg;
    logic             trap;
    logic [1:0]       trap_cause;
    logic [CNT_W-1:0] instret;
    logic             busy;

    ctl_t             obs;
    int               total;
    int               bad;
    logic [CNT_W-1:0] exp_ret;

    multicycle_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .opcode       (opcode),
        .branch_taken (branch_taken),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .iord         (iord),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .alu_op       (alu_op),
        .alu_src      (alu_src),
        .reg_write    (reg_write),
        .mem_to_reg   (mem_to_reg),
        .trap         (trap),
        .trap_cause   (trap_cause),
        .instret      (instret),
        .busy         (busy)
    );

    assign obs = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_op,
                  alu_src, reg_write, mem_to_reg, trap, trap_cause, busy};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int op_class(input logic [6:0] op);
        case (op)
            7'b0000011: return C_LOAD;
            7'b0100011: return C_STORE;
            7'b0110011: return C_R;
            7'b0010011: return C_IMM;
            7'b0110111: return C_LUI;
            7'b1100011: return C_BRANCH;
            7'b1101111: return C_JAL;
            7'b1100111: return C_JALR;
            default:    return C_ILL;
        endcase
    endfunction

    // Zero-wait cycles per instruction for each class.
    function automatic int latency(input int k);
        case (k)
            C_LOAD:                return 5;
            C_STORE, C_R, C_IMM, C_LUI: return 4;
            default:               return 3;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Inputs are already driven (just after a rising edge); compare at the falling edge.
    task automatic cyc(input string tag, input ctl_t e);
        @(negedge clk);
        chk(tag, 64'(obs), 64'(e));
        chk({tag, "_instret"}, 64'(instret), 64'(exp_ret));
        @(posedge clk);
        #1;
    endtask

    task automatic noise();
        run          = 1'($urandom);
        mem_ready    = 1'($urandom);
        branch_taken = 1'($urandom);
    endtask

    task automatic do_reset();
        ctl_t e;
        reset   = 1'b1;
        noise();
        opcode  = 7'($urandom);
        exp_ret = '0;
        e       = '0;
        cyc("reset", e);
        reset = 1'b0;
    endtask

    task automatic expect_trap(input logic [1:0] cause);
        ctl_t e;
        for (int n = 0; n < 3; n++) begin
            noise();
            e            = '0;
            e.trap       = 1'b1;
            e.trap_cause = cause;
            cyc("trap", e);
        end
    endtask

    // One whole instruction: fw / aw are wait cycles before mem_ready in fetch / access;
    // rst_at >= 0 asserts reset after that many access cycles instead of finishing.
    task automatic do_instr(input logic [6:0] op, input int fw, input int aw,
                            input logic taken, input int rst_at, output logic stopped);
        ctl_t e;
        int   k;
        int   ncyc;
        stopped = 1'b0;
        ncyc    = 0;
        k       = op_class(op);

        for (int i = 0; i <= fw; i++) begin
            if (i == TO) begin
                expect_trap(2'b10);
                stopped = 1'b1;
                return;
            end
            run          = 1'b1;
            mem_ready    = (i == fw);
            opcode       = 7'($urandom);
            branch_taken = 1'($urandom);
            e            = '0;
            e.mem_req    = 1'b1;
            e.busy       = 1'b1;
            if (i == fw) begin
                e.ir_write = 1'b1;
                e.pc_write = 1'b1;
            end
            cyc("fetch", e);
            ncyc++;
        end

        noise();
        opcode = op;
        e      = '0;
        e.busy = 1'b1;
        cyc("decode", e);
        ncyc++;

        if (k == C_ILL) begin
            expect_trap(2'b01);
            stopped = 1'b1;
            return;
        end

        e      = '0;
        e.busy = 1'b1;
        case (k)
            C_LOAD, C_STORE: begin
                noise();
                e.alu_op  = 2'b01;
                e.alu_src = 1'b1;
                cyc("mem_addr", e);
                ncyc++;
                for (int i = 0; i <= aw; i++) begin
                    if (i == rst_at) begin
                        do_reset();
                        stopped = 1'b1;
                        return;
                    end
                    if (i == TO) begin
                        expect_trap(2'b10);
                        stopped = 1'b1;
                        return;
                    end
                    noise();
                    mem_ready = (i == aw);
                    e         = '0;
                    e.busy    = 1'b1;
                    e.mem_req = 1'b1;
                    e.iord    = 1'b1;
                    e.mem_we  = (k == C_STORE);
                    cyc("mem_acc", e);
                    ncyc++;
                end
                if (k == C_LOAD) begin
                    noise();
                    e            = '0;
                    e.busy       = 1'b1;
                    e.reg_write  = 1'b1;
                    e.mem_to_reg = 2'b01;
                    cyc("wb_mem", e);
                    ncyc++;
                end
                exp_ret++;
            end
            C_R, C_IMM, C_LUI: begin
                e.alu_src = (k != C_R);
                e.alu_op  = (k == C_R) ? 2'b10 : (k == C_LUI) ? 2'b11 : 2'b00;
                noise();
                cyc("exec", e);
                ncyc++;
                noise();
                e.reg_write = 1'b1;
                cyc("wb_alu", e);
                ncyc++;
                exp_ret++;
            end
            C_BRANCH: begin
                noise();
                branch_taken = taken;
                e.alu_op     = 2'b11;
                e.pc_src     = 2'b01;
                e.pc_write   = taken;
                cyc("branch", e);
                ncyc++;
                exp_ret++;
            end
            default: begin
                noise();
                e.reg_write  = 1'b1;
                e.mem_to_reg = 2'b10;
                e.pc_write   = 1'b1;
                e.pc_src     = (k == C_JALR) ? 2'b11 : 2'b10;
                e.alu_src    = (k == C_JALR);
                e.alu_op     = (k == C_JALR) ? 2'b01 : 2'b00;
                cyc("jump", e);
                ncyc++;
                exp_ret++;
            end
        endcase

        if (fw == 0 && aw == 0) begin
            chk("latency", 64'(ncyc), 64'(latency(k)));
        end
    endtask

    initial begin
        logic [6:0] legal_ops [8];
        logic       stopped;
        logic [6:0] op;
        int         fw;
        int         aw;
        ctl_t       e;

        legal_ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                      7'b0110111, 7'b1100011, 7'b1101111, 7'b1100111};
        total        = 0;
        bad          = 0;
        exp_ret      = '0;
        reset        = 1'b1;
        run          = 1'b0;
        opcode       = '0;
        branch_taken = 1'b0;
        mem_ready    = 1'b0;
        @(posedge clk);
        #1;
        do_reset();
        do_reset();

        // ADD, LOAD with 3 wait states, STORE, branches, jumps, immediates.
        do_instr(7'b0110011, 0, 0, 1'b0, -1, stopped);
        do_instr(7'b0000011, 0, 3, 1'b0, -1, stopped);
        do_instr(7'b0100011, 0, 0, 1'b0, -1, stopped);
        do_instr(7'b1100011, 0, 0, 1'b1, -1, stopped);
        do_instr(7'b1100011, 0, 0, 1'b0, -1, stopped);
        do_instr(7'b1100111, 0, 0, 1'b0, -1, stopped);
        do_instr(7'b1101111, 0, 0, 1'b0, -1, stopped);
        do_instr(7'b0010011, 0, 0, 1'b0, -1, stopped);
        do_instr(7'b0110111, 0, 0, 1'b0, -1, stopped);
        // mem_ready on the very cycle the wait budget would run out.
        do_instr(7'b0000011, TO - 1, TO - 1, 1'b0, -1, stopped);

        // Idle in FETCH: no request, not busy, mem_ready ignored.
        for (int n = 0; n < 3; n++) begin
            run          = 1'b0;
            mem_ready    = 1'($urandom);
            branch_taken = 1'($urandom);
            e            = '0;
            cyc("idle", e);
        end

        // Random stream, occasionally with an arbitrary (possibly illegal) opcode.
        for (int n = 0; n < 80; n++) begin
            op = legal_ops[$urandom_range(0, 7)];
            if ($urandom_range(0, 9) == 0) begin
                op = 7'($urandom);
            end
            fw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TO - 1)) : 0;
            aw = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, TO - 1)) : 0;
            do_instr(op, fw, aw, 1'($urandom), -1, stopped);
            if (stopped) begin
                do_reset();
            end
        end

        // Illegal opcode traps with cause 01 and stays halted until reset.
        do_instr(7'b0110011, 0, 0, 1'b0, -1, stopped);
        do_instr(7'b1111111, 0, 0, 1'b0, -1, stopped);
        chk("illegal_stops", 64'(stopped), 64'(1));
        do_reset();

        // Fetch never answered: trap with cause 10 on the 16th cycle.
        do_instr(7'b0110011, TO + 5, 0, 1'b0, -1, stopped);
        chk("fetch_timeout_stops", 64'(stopped), 64'(1));
        do_reset();

        // Store access never answered.
        do_instr(7'b0100011, 0, TO + 5, 1'b0, -1, stopped);
        do_reset();

        // Reset during a pending load access, then a clean instruction.
        do_instr(7'b0010011, 0, 0, 1'b0, -1, stopped);
        do_instr(7'b0000011, 0, 6, 1'b0, 2, stopped);
        do_instr(7'b0110011, 0, 0, 1'b0, -1, stopped);
        @(negedge clk);
        chk("instret_after_reset", 64'(instret), 64'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore-style FSM that sequences the RISC-V multi-cycle datapath: PC, IR, register file, ALU and a single shared instruction/data memory port.
- Decodes the 7-bit opcode held in IR.
- Drives all datapath strobes and mux selects, and handles variable-latency memory with a request/ready handshake and a timeout.
- Sits between the IR and the datapath, in place of a purely combinational opcode decoder.

Parameters:
MEM_TIMEOUT, 15, max wait cycles for mem_ready per access before bus-error trap (1..255)
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
run  input  1  allow new instruction fetch; sampled only in FETCH
opcode  input  7  IR[6:0], valid from DECODE onward
branch_taken  input  1  ALU compare result, valid in BRANCH
mem_ready  input  1  memory completes current access this cycle
mem_req  output  1  memory access request
mem_we  output  1  1 = write (store)
iord  output  1  address mux: 0 = PC, 1 = ALU result
ir_write  output  1  latch memory read data into IR
pc_write  output  1  update PC
pc_src  output  2  00 PC+4, 01 branch target, 10 JAL target, 11 JALR (ALU result)
alu_op  output  2  00 imm, 01 address add, 10 R-type, 11 compare/LUI
alu_src  output  1  0 = rs2, 1 = immediate
reg_write  output  1  register file write enable
mem_to_reg  output  2  00 ALU, 01 memory data, 10 PC+4 (link)
trap  output  1  sticky: core halted
trap_cause  output  2  00 none, 01 illegal opcode, 10 bus timeout
instret  output  CNT_W  retired-instruction count
busy  output  1  high in any state except FETCH-idle and TRAP

Behaviour:
- Opcode classes:
  - LOAD 0000011
  - STORE 0100011
  - R 0110011
  - IMM 0010011
  - LUI 0110111
  - BRANCH 1100011
  - JAL 1101111
  - JALR 1100111
  - Any other opcode = illegal.
- Reset (synchronous, has priority over everything): state=FETCH, wait counter=0, instret=0, trap=0, trap_cause=00. All outputs are 0 in the reset cycle.
- Unlisted outputs are 0 in every state.
- States:
  - FETCH: mem_req=run, iord=0.
    - run=0: stay in FETCH, no request (idle).
    - run=1 & mem_ready=1: ir_write=1, pc_write=1, pc_src=00, go to DECODE.
  - DECODE: 1 cycle.
    - LOAD/STORE -> MEM_ADDR
    - R/IMM/LUI -> EXEC
    - BRANCH -> BRANCH
    - JAL/JALR -> JUMP
    - illegal -> TRAP, with trap_cause=01.
  - MEM_ADDR: alu_op=01, alu_src=1; 1 cycle -> MEM_ACC.
  - MEM_ACC: mem_req=1, iord=1, mem_we=(STORE).
    - On mem_ready: STORE -> FETCH (retire); LOAD -> WB_MEM.
  - WB_MEM: reg_write=1, mem_to_reg=01; retire -> FETCH.
  - EXEC: alu_src=1 for IMM/LUI and 0 for R; alu_op = 00 (IMM), 10 (R), 11 (LUI); -> WB_ALU.
  - WB_ALU: reg_write=1, mem_to_reg=00, ALU controls held from EXEC; retire -> FETCH.
  - BRANCH: alu_op=11, alu_src=0, pc_src=01, pc_write=branch_taken; retire -> FETCH.
  - JUMP: reg_write=1, mem_to_reg=10, pc_write=1, pc_src=10 (JAL) or 11 (JALR). For JALR, alu_src=1 and alu_op=01. Retire -> FETCH.
  - TRAP: all strobes 0, trap=1. Only reset exits TRAP.
- Retire: instret increments by 1 on the cycle the final state of an instruction is left. It wraps modulo 2^CNT_W. It does not increment on trap.
- Memory handshake:
  - mem_req stays asserted, with stable mem_we/iord, until the cycle mem_ready=1 (inclusive).
  - mem_ready is ignored when mem_req=0.
- Timeout:
  - The wait counter clears on entry to FETCH/MEM_ACC and on each mem_ready.
  - It increments each cycle mem_req=1 & mem_ready=0.
  - When the counter reaches MEM_TIMEOUT without mem_ready, the FSM goes to TRAP next cycle with trap_cause=10.
  - If mem_ready arrives in the same cycle the counter hits the limit, mem_ready wins.
- run deasserted mid-instruction has no effect; the instruction completes and the FSM idles in FETCH.
- Reset mid-access: mem_req drops in the reset cycle. The next fetch starts cleanly from FETCH.
- Latency with zero-wait memory (cycles per instruction):
  - R/IMM/LUI: 4
  - LOAD: 5
  - STORE: 4
  - BRANCH/JAL/JALR: 3

Test Plan:
1. Reset, run=1, mem_ready always 1, IR=ADD (0110011) -> FETCH, DECODE, EXEC(alu_op=10, alu_src=0), WB_ALU(reg_write=1, mem_to_reg=00); instret=1 after 4 cycles.
2. LOAD with mem_ready delayed 3 cycles in MEM_ACC -> mem_req=1, iord=1, mem_we=0 held 4 cycles, then WB_MEM mem_to_reg=01; STORE -> mem_we=1 and no reg_write; instret=2.
3. BRANCH with branch_taken=1, then with branch_taken=0 -> pc_write=1 with pc_src=01, then pc_write=0; each takes 3 cycles.
4. JALR -> JUMP state: reg_write=1, mem_to_reg=10, pc_src=11, pc_write=1.
5. Opcode 1111111 -> TRAP, trap_cause=01, instret unchanged, no mem_req thereafter; reset clears trap.
6. mem_ready held 0 in FETCH with MEM_TIMEOUT=15 -> trap_cause=10 on the 16th cycle. Separately, reset asserted mid MEM_ACC -> all outputs 0 that cycle, then a clean FETCH with instret=0.
